// File: rtl/set_flag_gen.sv
// Multi-cycle compare-flag generator: diff = a - b computed SLICE bits per cycle, LSB first,
// producing a_msb/b_msb/diff_msb/is_not_zero. Define SET_FLAG_OVF_EN to add the signed-overflow output ovf.
module set_flag_gen #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             a_msb,
  output logic             b_msb,
  output logic             diff_msb,
  output logic             is_not_zero
`ifdef SET_FLAG_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             nz_acc_q, nz_acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             diff_msb_q, diff_msb_d;
  logic             is_nz_q, is_nz_d;
  logic             out_valid_q, out_valid_d;
`ifdef SET_FLAG_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  int unsigned      sh;
  logic [SLICE-1:0] a_sl, nb_sl;
  logic [SLICE:0]   sum;

  // Current slice is selected by shifting, so the adder is SLICE bits wide regardless of WIDTH.
  always_comb begin
    sh    = int'(cnt_q) * SLICE;
    a_sl  = SLICE'(a_q >> sh);
    nb_sl = SLICE'(nb_q >> sh);
    sum   = {1'b0, a_sl} + {1'b0, nb_sl} + {{SLICE{1'b0}}, carry_q};
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    nz_acc_d    = nz_acc_q;
    a_d         = a_q;
    nb_d        = nb_q;
    diff_d      = diff_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    diff_msb_d  = diff_msb_q;
    is_nz_d     = is_nz_q;
    out_valid_d = out_valid_q;
`ifdef SET_FLAG_OVF_EN
    ovf_d       = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          nb_d     = ~b;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          carry_d  = 1'b1;
          cnt_d    = '0;
          nz_acc_d = 1'b0;
          state_d  = CALC;
        end
      end
      CALC: begin
        diff_d   = (diff_q & ~(SLICE_MASK << sh)) | (WIDTH'(sum[SLICE-1:0]) << sh);
        carry_d  = sum[SLICE];
        nz_acc_d = nz_acc_q | (|sum[SLICE-1:0]);
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          diff_msb_d  = sum[SLICE-1];
          is_nz_d     = nz_acc_d;
          out_valid_d = 1'b1;
          state_d     = HOLD;
`ifdef SET_FLAG_OVF_EN
          ovf_d       = (a_msb_q != b_msb_q) && (sum[SLICE-1] != a_msb_q);
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b1;
      nz_acc_q    <= 1'b0;
      a_q         <= '0;
      nb_q        <= '0;
      diff_q      <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      diff_msb_q  <= 1'b0;
      is_nz_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SET_FLAG_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      nz_acc_q    <= nz_acc_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      diff_q      <= diff_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      diff_msb_q  <= diff_msb_d;
      is_nz_q     <= is_nz_d;
      out_valid_q <= out_valid_d;
`ifdef SET_FLAG_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign diff        = diff_q;
  assign a_msb       = a_msb_q;
  assign b_msb       = b_msb_q;
  assign diff_msb    = diff_msb_q;
  assign is_not_zero = is_nz_q;
`ifdef SET_FLAG_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_set_flag_gen.sv
// Self-checking bench for set_flag_gen: directed cases plus randomized transactions against
// a plain-arithmetic reference (diff = a - b). Honours SET_FLAG_OVF_EN when defined.
module tb_set_flag_gen;

  localparam int W      = 32;
  localparam int NSLICE = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         a_msb, b_msb, diff_msb, is_not_zero;
`ifdef SET_FLAG_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  set_flag_gen #(.WIDTH(W), .SLICE(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .a_msb      (a_msb),
    .b_msb      (b_msb),
    .diff_msb   (diff_msb),
    .is_not_zero(is_not_zero)
`ifdef SET_FLAG_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    logic [W-1:0] e;
    logic [3:0]   ef;
    e  = ta - tb_v;
    ef = {ta[W-1], tb_v[W-1], e[W-1], (e != '0)};
    check({tag, "_diff"}, diff, e);
    check({tag, "_flags"}, W'({a_msb, b_msb, diff_msb, is_not_zero}), W'(ef));
`ifdef SET_FLAG_OVF_EN
    check({tag, "_ovf"}, W'(ovf), W'((ta[W-1] != tb_v[W-1]) && (e[W-1] != ta[W-1])));
`endif
  endtask

  // One full transaction; stall = cycles of out_ready=0 in HOLD, poke = offer new operands meanwhile.
  task automatic do_txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input int stall, input bit poke);
    int  acc;
    bit  seen;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, W'(in_ready), W'(1));
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    out_ready = (stall == 0);
    acc       = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    seen     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, seen ? W'(cyc - acc) : '1, W'(NSLICE));
    if (seen) begin
      check_flags(tag, ta, tb_v);
      check({tag, "_busy"}, W'(in_ready), W'(0));
      for (int i = 0; i < stall; i++) begin
        if (poke) begin
          in_valid = 1'b1;
          a        = $urandom;
          b        = $urandom;
        end
        @(negedge clk);
        check({tag, "_hold_valid"}, W'(out_valid), W'(1));
        check({tag, "_hold_ready"}, W'(in_ready), W'(0));
        check_flags({tag, "_hold"}, ta, tb_v);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_release_valid"}, W'(out_valid), W'(0));
      check({tag, "_release_ready"}, W'(in_ready), W'(1));
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int acc1, acc2, mode, stall;
    bit seen, got1;
    logic [W-1:0] ra, rb;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_diff", diff, '0);
    check("rst_flags", W'({a_msb, b_msb, diff_msb, is_not_zero}), '0);
    reset = 1'b0;

    do_txn("equal", 32'd5, 32'd5, 0, 1'b0);
    do_txn("neg", 32'd3, 32'd7, 1, 1'b0);
    do_txn("mixed_ovf", 32'h8000_0000, 32'h0000_0001, 0, 1'b0);
    do_txn("backpressure", 32'h10, 32'h01, 6, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("no_ghost_after_bp", W'(out_valid), W'(0));
    end

    // Reset sampled at the end of the second CALC cycle discards the result.
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = '0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready", W'(in_ready), W'(1));
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_diff", diff, '0);
    check("midrst_flags", W'({a_msb, b_msb, diff_msb, is_not_zero}), '0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", W'(seen), W'(0));

    // Back-to-back with in_valid held high: accepts must be NSLICE+2 cycles apart.
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 32'd1; b = 32'd2;
    acc1 = cyc + 1;
    @(negedge clk);
    a = 32'd2; b = 32'd1;
    got1 = 1'b0; acc2 = -100;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && !got1) begin
        got1 = 1'b1;
        check_flags("b2b_first", 32'd1, 32'd2);
      end
      if (in_ready) begin
        acc2 = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    check("b2b_first_seen", W'(got1), W'(1));
    check("b2b_spacing", W'(acc2 - acc1), W'(NSLICE + 2));
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("b2b_second_seen", W'(seen), W'(1));
    if (seen) check_flags("b2b_second", 32'd2, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;

    for (int n = 0; n < 25; n++) begin
      mode  = $urandom_range(0, 3);
      stall = $urandom_range(0, 3);
      ra    = $urandom;
      rb    = $urandom;
      case (mode)
        0: rb = ra;
        1: begin ra = {ra[0], {(W-1){1'b0}}}; rb = {rb[0], {(W-1){rb[1]}}}; end
        2: begin ra = ra & 32'h0000_01FF; rb = rb & 32'h0000_01FF; end
        default: ;
      endcase
      do_txn("rand", ra, rb, stall, 1'(mode == 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
